// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray-code types and width-generic conversion helpers
//
// Contents:
//   GRAY_MAX_W   widest code the helpers handle; narrower codes are zero-extended
//   state_t      tracker FSM states {IDLE, TRACK, ERR}
//   step_class_t classification of one sample-to-sample change {HOLD, UP, DN, JUMP}
//   gray2bin     prefix-XOR decode from the MSB
//   bin2gray     encode, shared with the binary-to-Gray encoder
package gray_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ERR   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        UP   = 2'd1,
        DN   = 2'd2,
        JUMP = 2'd3
    } step_class_t;

    // Zero upper bits leave the low bits untouched, so callers pass a
    // zero-extended code and keep only the low WIDTH bits of the result.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_step_classify.sv
// rtl/gray_step_classify.sv - combinational Gray decode and step classification
//
// Ports:
//   g_q        in   WIDTH  registered Gray sample
//   b_ref      in   WIDTH  binary value of the previous accepted sample
//   b_new      out  WIDTH  binary decode of g_q
//   step_class out  2      HOLD / UP / DN / JUMP of b_new relative to b_ref
module gray_step_classify
    import gray_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] g_q,
    input  logic [WIDTH-1:0] b_ref,
    output logic [WIDTH-1:0] b_new,
    output step_class_t      step_class
);

    logic [GRAY_MAX_W-1:0] b_full;
    logic [WIDTH-1:0]      delta;
    logic                  unused_hi;

    assign b_full    = gray2bin(GRAY_MAX_W'(g_q));
    assign b_new     = b_full[WIDTH-1:0];
    assign unused_hi = ^b_full[GRAY_MAX_W-1:WIDTH];

    // Modular difference: the wrap max->0 yields 1 and 0->max yields all-ones.
    assign delta = b_new - b_ref;

    always_comb begin
        step_class = JUMP;
        if (delta == '0) begin
            step_class = HOLD;
        end else if (delta == WIDTH'(1)) begin
            step_class = UP;
        end else if (delta == {WIDTH{1'b1}}) begin
            step_class = DN;
        end
    end

endmodule

// File: rtl/gray_to_binary_tracker.sv
// rtl/gray_to_binary_tracker.sv - registered Gray decoder with step tracking and sticky error
//
// Optional build macro: GRAY_TRACKER_SYNC_EN inserts a 2-flop synchronizer on
// gray_i/gray_vld ahead of stage 1 (latency 4 instead of 2).
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   gray_i    in   WIDTH  Gray-coded sample
//   gray_vld  in   1      gray_i valid this cycle
//   err_clr   in   1      clear sticky error, return FSM to IDLE
//   bin_o     out  WIDTH  binary of last accepted sample
//   bin_vld   out  1      one-cycle pulse when bin_o/status update
//   step_up   out  1      +1 step with bin_vld
//   step_dn   out  1      -1 step with bin_vld
//   step_err  out  1      sticky illegal-jump flag
//   pos_o     out  CNT_W  wrapping signed net step count
module gray_to_binary_tracker
    import gray_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_i,
    input  logic             gray_vld,
    input  logic             err_clr,
    output logic [WIDTH-1:0] bin_o,
    output logic             bin_vld,
    output logic             step_up,
    output logic             step_dn,
    output logic             step_err,
    output logic [CNT_W-1:0] pos_o
);

    logic [WIDTH-1:0] s1_gray_in;
    logic             s1_vld_in;

`ifdef GRAY_TRACKER_SYNC_EN
    logic [WIDTH-1:0] sync1_gray_q, sync2_gray_q;
    logic             sync1_vld_q, sync2_vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_gray_q <= '0;
            sync2_gray_q <= '0;
            sync1_vld_q  <= 1'b0;
            sync2_vld_q  <= 1'b0;
        end else begin
            sync1_gray_q <= gray_i;
            sync2_gray_q <= sync1_gray_q;
            sync1_vld_q  <= gray_vld;
            sync2_vld_q  <= sync1_vld_q;
        end
    end

    assign s1_gray_in = sync2_gray_q;
    assign s1_vld_in  = sync2_vld_q;
`else
    assign s1_gray_in = gray_i;
    assign s1_vld_in  = gray_vld;
`endif

    // Stage 1 registers
    logic [WIDTH-1:0] s1_gray_q, s1_gray_d;
    logic             s1_vld_q, s1_vld_d;

    // Stage 2 registers
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             bin_vld_q, bin_vld_d;
    logic             step_up_q, step_up_d;
    logic             step_dn_q, step_dn_d;
    logic             step_err_q, step_err_d;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic [WIDTH-1:0] b_ref_q, b_ref_d;
    state_t           state_q, state_d;

    logic [WIDTH-1:0] b_new;
    step_class_t      step_class;

    gray_step_classify #(
        .WIDTH (WIDTH)
    ) u_classify (
        .g_q        (s1_gray_q),
        .b_ref      (b_ref_q),
        .b_new      (b_new),
        .step_class (step_class)
    );

    always_comb begin
        s1_gray_d = s1_vld_in ? s1_gray_in : s1_gray_q;
        s1_vld_d  = s1_vld_in;
    end

    always_comb begin
        bin_d      = bin_q;
        bin_vld_d  = 1'b0;
        step_up_d  = 1'b0;
        step_dn_d  = 1'b0;
        step_err_d = step_err_q;
        pos_d      = pos_q;
        state_d    = state_q;
        b_ref_d    = b_ref_q;

        if (s1_vld_q) begin
            bin_d     = b_new;
            bin_vld_d = 1'b1;
            b_ref_d   = b_new;
            // A clear arriving with the sample makes it a fresh seed.
            if (err_clr || state_q == IDLE) begin
                state_d = TRACK;
            end else begin
                case (step_class)
                    UP: begin
                        step_up_d = 1'b1;
                        pos_d     = pos_q + CNT_W'(1);
                    end
                    DN: begin
                        step_dn_d = 1'b1;
                        pos_d     = pos_q - CNT_W'(1);
                    end
                    JUMP: begin
                        // From ERR this is absorbed: flag already set, state unchanged.
                        step_err_d = 1'b1;
                        state_d    = ERR;
                    end
                    default: begin
                    end
                endcase
            end
        end

        if (err_clr) begin
            step_err_d = 1'b0;
            if (!s1_vld_q) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_gray_q  <= '0;
            s1_vld_q   <= 1'b0;
            bin_q      <= '0;
            bin_vld_q  <= 1'b0;
            step_up_q  <= 1'b0;
            step_dn_q  <= 1'b0;
            step_err_q <= 1'b0;
            pos_q      <= '0;
            b_ref_q    <= '0;
            state_q    <= IDLE;
        end else begin
            s1_gray_q  <= s1_gray_d;
            s1_vld_q   <= s1_vld_d;
            bin_q      <= bin_d;
            bin_vld_q  <= bin_vld_d;
            step_up_q  <= step_up_d;
            step_dn_q  <= step_dn_d;
            step_err_q <= step_err_d;
            pos_q      <= pos_d;
            b_ref_q    <= b_ref_d;
            state_q    <= state_d;
        end
    end

    assign bin_o    = bin_q;
    assign bin_vld  = bin_vld_q;
    assign step_up  = step_up_q;
    assign step_dn  = step_dn_q;
    assign step_err = step_err_q;
    assign pos_o    = pos_q;

endmodule

// File: doc/gray_to_binary_tracker.md
Name: gray_to_binary_tracker

Overview:
- Registered Gray-to-binary decoder for Gray-coded position/count sources such as encoder wheels and Gray counters. It is the receive-side counterpart of the team's binary-to-Gray encoder.
- Decodes each sampled Gray word to binary and classifies the change against the previous sample as hold, up-step, down-step or illegal jump.
- Maintains a wrapping signed step accumulator and a sticky error flag.
- Sits between the Gray source and downstream control logic.

Parameters:
WIDTH, 3, Gray/binary code width in bits (>=2)
CNT_W, 8, width of the step accumulator pos_o (two's complement, wraps)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
gray_i  input  WIDTH  Gray-coded sample
gray_vld  input  1  gray_i is valid this cycle
err_clr  input  1  clears sticky error; returns FSM to IDLE
bin_o  output  WIDTH  decoded binary of last accepted sample
bin_vld  output  1  one-cycle pulse: bin_o/status updated
step_up  output  1  pulse with bin_vld: +1 step detected
step_dn  output  1  pulse with bin_vld: -1 step detected
step_err  output  1  sticky: illegal jump seen since last clear
pos_o  output  CNT_W  signed net step count

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low. Assertion immediately clears all state; deassertion is used synchronously.
- Reset values: bin_o=0, bin_vld=0, step_up=0, step_dn=0, step_err=0, pos_o=0, FSM=IDLE, internal reference=0.
- Pipeline: stage 1 registers gray_i when gray_vld=1. Stage 2 decodes, compares and updates the outputs.
- Latency: gray_vld sampled at edge k produces outputs at edge k+2. bin_vld stays high for exactly one cycle per accepted sample. Back-to-back samples are accepted every cycle; there is no backpressure.
- Decode: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i] (prefix XOR from MSB).
- Delta: d = (b_new - b_ref) mod 2^WIDTH.
  - d=0: hold, no step.
  - d=1: step_up, pos_o+1.
  - d=2^WIDTH-1: step_dn, pos_o-1.
  - Otherwise: illegal jump.
  - b_ref <= b_new on every accepted sample.
- FSM:
  - IDLE: the first accepted sample seeds b_ref and updates bin_o with bin_vld=1, but no step, no error and pos unchanged. Then -> TRACK.
  - TRACK: hold/step handled as above. Illegal jump sets step_err=1 and pos unchanged, then -> ERR.
  - ERR: bin_o/bin_vld/b_ref keep updating. Steps are still classified and counted. Further illegal jumps are absorbed; step_err stays 1.
  - err_clr=1 in any state: step_err<=0, FSM<=IDLE next edge.
- Simultaneous err_clr and a stage-2 sample: clear wins. The sample is treated as an IDLE seed (no step, no error).
- Wrap-around: binary 2^WIDTH-1 -> 0 is an up-step, and 0 -> 2^WIDTH-1 is a down-step. pos_o wraps modulo 2^CNT_W without saturation.
- Reset mid-stream: in-flight stage-1 data is discarded and no bin_vld is issued for it.

Optional Feature:
- Macro: GRAY_TRACKER_SYNC_EN.
- Defined: a 2-flop synchronizer on gray_i and gray_vld precedes stage 1, and its flops reset to 0. Latency becomes 4 clocks. Gray coding keeps the multi-bit bus safe for single-bit-change sources.
- Undefined: inputs go straight to stage 1 with latency 2.

Decomposition:
- Package gray_pkg:
  - state enum {IDLE, TRACK, ERR}
  - function gray2bin(WIDTH-generic)
  - function bin2gray, shared with the encoder
  - step-class enum {HOLD, UP, DN, JUMP}
- Sub-module gray_step_classify: combinational decode plus delta classification from (g_q, b_ref) to (b_new, class). The top holds the registers, FSM and accumulator.

Test Plan:
- Reset: drive gray_i=3'b101, gray_vld=1, hold rst_n=0 -> all outputs 0, no bin_vld. Assert rst_n low mid-operation -> outputs 0 immediately.
- Up sweep (WIDTH=3): gray 000,001,011,010,110,111,101,100,000 on consecutive cycles -> bin_o 0..7,0. First sample seeds; step_up on the next 8 samples; pos_o=8'd8; step_err=0.
- Down wrap: seed 000, then 100 -> bin_o=7, step_dn=1, pos_o=8'hFF.
- Hold: seed 011, then 011 -> second bin_vld pulse with bin_o=2, step_up=step_dn=0, pos_o unchanged.
- Illegal jump then clear: seed 000, then 011 (bin 2) -> step_err=1 and stays 1, pos_o=0. Pulse err_clr coincident with sample 001 -> step_err=0, 001 seeds (no step). Next 011 -> step_up, pos_o=1.
- Reset mid-stream: reach pos_o=5, then pulse rst_n with a sample in stage 1 -> pos_o=0, no bin_vld for the dropped sample. Next sample only seeds.
